cernbe_master: RTL

Bus initiator for the CERN-BE register-bank interface (`VMEAddr`/`VMERdMem`/`VMEWrMem`/`Done`/`Error`). It drives the generated register banks and serves a firmware-side command port. It converts one valid/ready command into a single-cycle read or write strobe, then holds address and data stable until the bank completes. It then returns read data and status on a valid/ready response port. An optional timeout guarantees completion when a bank never acknowledges.

---
 rtl/cernbe_master_if.sv | 39 +++
 rtl/cernbe_master.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cernbe_master_if.sv
// Command, response and register-bank bus bundle for cernbe_master.
// The master modport is the initiator's view; slave is the firmware/bank side.
interface cernbe_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [17:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    logic [17:0] VMEAddr;
    logic [31:0] VMEWrData;
    logic        VMERdMem;
    logic        VMEWrMem;
    logic [31:0] VMERdData;
    logic        VMERdDone;
    logic        VMEWrDone;
    logic        VMERdError;
    logic        VMEWrError;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
               VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               VMEAddr, VMEWrData, VMERdMem, VMEWrMem
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
               VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               VMEAddr, VMEWrData, VMERdMem, VMEWrMem
    );
endinterface

// File: rtl/cernbe_master.sv
// CERN-BE register-bank initiator: one command -> one strobe -> one response.
// Define CERNBE_MASTER_TIMEOUT_EN to build the completion timeout counter.
module cernbe_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic             Clk,
    input logic             Rst,
    cernbe_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    // Out-of-range limits are rejected at elaboration.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cernbe_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t      state_reg;
    logic        we_reg;
    logic        cmd_ready_reg;
    logic        rsp_valid_reg;
    logic        rsp_err_reg;
    logic [31:0] rsp_rdata_reg;
    logic [17:0] addr_reg;
    logic [31:0] wr_data_reg;
    logic        rd_mem_reg;
    logic        wr_mem_reg;
    logic        done_sel;
    logic        err_sel;

    // Only the completion pair matching the latched direction is observed.
    assign done_sel = we_reg ? bus.VMEWrDone  : bus.VMERdDone;
    assign err_sel  = we_reg ? bus.VMEWrError : bus.VMERdError;

`ifdef CERNBE_MASTER_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_reg;
    logic        rsp_timeout_reg;
    assign bus.rsp_timeout = rsp_timeout_reg;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            addr_reg      <= '0;
            wr_data_reg   <= '0;
            rd_mem_reg    <= 1'b0;
            wr_mem_reg    <= 1'b0;
`ifdef CERNBE_MASTER_TIMEOUT_EN
            wait_cnt_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
`endif
        end else begin
            rd_mem_reg <= 1'b0;
            wr_mem_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_reg) begin
                        addr_reg      <= bus.cmd_addr;
                        wr_data_reg   <= bus.cmd_wdata;
                        we_reg        <= bus.cmd_we;
                        rd_mem_reg    <= !bus.cmd_we;
                        wr_mem_reg    <= bus.cmd_we;
                        cmd_ready_reg <= 1'b0;
                        state_reg     <= STROBE;
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                STROBE, WAIT: begin
                    // Error wins over Done, but read data is still captured.
                    if (done_sel || err_sel) begin
                        rsp_rdata_reg <= (!we_reg && done_sel) ? bus.VMERdData : 32'd0;
                        rsp_err_reg   <= err_sel;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
`ifdef CERNBE_MASTER_TIMEOUT_EN
                        rsp_timeout_reg <= 1'b0;
                    end else if (state_reg == STROBE) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        rsp_rdata_reg   <= '0;
                        rsp_err_reg     <= 1'b1;
                        rsp_timeout_reg <= 1'b1;
                        rsp_valid_reg   <= 1'b1;
                        state_reg       <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
`else
                    end else begin
                        state_reg <= WAIT;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.VMEAddr   = addr_reg;
    assign bus.VMEWrData = wr_data_reg;
    assign bus.VMERdMem  = rd_mem_reg;
    assign bus.VMEWrMem  = wr_mem_reg;
endmodule
